// File: rtl/lenet_pkg.sv
// Shared types and constants for the LeNet UART front end.
// Frame geometry, sync marker, error causes and the map assembler FSM states.
package lenet_pkg;

    localparam int         MAP_BYTES = 36;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_CSUM    = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_code_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHK     = 2'd2,
        ST_EMIT    = 2'd3
    } asm_state_e;

endpackage

// File: rtl/uart_map_assembler_gap_timer.sv
// Saturating cycle counter with synchronous clear; flags when it sits at TERMINAL.
// Shared by the RX framer and the TX side for inter-byte gap supervision.
module gap_timer #(
    parameter int TERMINAL = 69999,
    parameter int WIDTH    = $clog2(TERMINAL + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic terminal_o
);

    localparam logic [WIDTH-1:0] TERM_V = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    assign terminal_o = (cnt_q == TERM_V);

    // Holds at terminal count so a stalled frame never wraps back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !terminal_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_map_assembler.sv
// Assembles a sync-prefixed, checksummed UART frame into one feature map word.
// Good frames pulse wr_en with the map; checksum failures and gaps pulse frame_err.
module uart_map_assembler #(
    parameter int         MAP_BYTES   = lenet_pkg::MAP_BYTES,
    parameter logic [7:0] SYNC_BYTE   = lenet_pkg::SYNC_BYTE,
    parameter int         TIMEOUT_CYC = 70000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    output logic                   wr_en,
    output logic [MAP_BYTES*8-1:0] wr_data,
    output logic                   frame_err,
    output logic [1:0]             err_code,
    output logic                   busy
);

    import lenet_pkg::*;

    localparam int DW = MAP_BYTES * 8;
    localparam int BW = $clog2(MAP_BYTES);
    localparam int GW = $clog2(TIMEOUT_CYC);
    localparam logic [BW-1:0] LAST_IDX = BW'(MAP_BYTES - 1);

    asm_state_e      state_q, state_d;
    logic [BW-1:0]   idx_q, idx_d;
    logic [7:0]      acc_q, acc_d;
    logic [DW-1:0]   shift_q, shift_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic            wr_en_q, wr_en_d;
    logic            frame_err_q, frame_err_d;
    err_code_e       err_q, err_d;
    logic            busy_q, busy_d;

    logic in_frame, is_sync, gap_term, timeout;

    assign in_frame = (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
    assign is_sync  = rx_valid && (rx_data == SYNC_BYTE);
    // A byte arriving on the terminal cycle takes priority over the timeout.
    assign timeout  = in_frame && gap_term && !rx_valid;

    gap_timer #(
        .TERMINAL (TIMEOUT_CYC - 1),
        .WIDTH    (GW)
    ) u_gap_timer (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (rx_valid || !in_frame),
        .enable_i   (in_frame),
        .terminal_o (gap_term)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        shift_d     = shift_q;
        wr_data_d   = wr_data_q;
        err_d       = err_q;
        frame_err_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_EMIT: begin
                if (is_sync) begin
                    state_d = ST_PAYLOAD;
                    idx_d   = '0;
                    acc_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (rx_valid) begin
                    shift_d = {shift_q[DW-9:0], rx_data};
                    acc_d   = acc_q + rx_data;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_CHK;
                    end
                end else if (timeout) begin
                    frame_err_d = 1'b1;
                    err_d       = ERR_TIMEOUT;
                    state_d     = ST_IDLE;
                end
            end
            ST_CHK: begin
                if (rx_valid) begin
                    if (rx_data == acc_q) begin
                        state_d   = ST_EMIT;
                        wr_data_d = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                        err_d       = ERR_CSUM;
                        state_d     = ST_IDLE;
                    end
                end else if (timeout) begin
                    frame_err_d = 1'b1;
                    err_d       = ERR_TIMEOUT;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        wr_en_d = (state_d == ST_EMIT);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            shift_q     <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            frame_err_q <= 1'b0;
            err_q       <= ERR_NONE;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            shift_q     <= shift_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
            frame_err_q <= frame_err_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_data   = wr_data_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_q;
    assign busy      = busy_q;

endmodule
